// File: rtl/lfsr_dec_pkg.sv
// Shared state encoding and memory-map constants for the LFSR decryption sequencer.
package lfsr_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LDPT,
    ST_SEED,
    ST_SRCH,
    ST_DEC,
    ST_PAD,
    ST_DONE
  } state_e;

  localparam logic [7:0]  SPACE      = 8'h20;
  localparam int unsigned PTRN_CNT   = 9;
  localparam int unsigned OUT_LEN    = 64;
  localparam int unsigned PRE_CHECK  = 10;
  localparam logic [7:0]  PTRN_BASE  = 8'd128;
  localparam logic [7:0]  CRYPT_BASE = 8'd64;

endpackage

// File: rtl/lfsr7_step.sv
// One step of the 7-bit Fibonacci LFSR: shift left, feed back parity of tapped bits.
module lfsr7_step (
  input  logic [6:0] state_i,
  input  logic [6:0] ptrn_i,
  output logic [6:0] next_o
);

  assign next_o = {state_i[5:0], ^(state_i & ptrn_i)};

endmodule

// File: rtl/lfsr_decrypt_seq.sv
// Program-3 sequencer: find LFSR taps/seed from the space preamble, decrypt, strip leading spaces.
// Optional macro LFSR_DEC_PERR_EN: flag parity errors in bit 7 and never drop a corrupted space.
module lfsr_decrypt_seq
  import lfsr_dec_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic       NoMatch,
  output logic [3:0] PtrnIdx,
  output logic       MemOwn,
  output logic [7:0] MemAddr,
  output logic       MemRdEn,
  output logic       MemWrEn,
  output logic [7:0] MemWdata,
  input  logic [7:0] MemRdata
);

  localparam int unsigned PTRN_W = PTRN_CNT * 7;

  state_e            state_q, state_d;
  logic [PTRN_W-1:0] ptrn_q, ptrn_d;
  logic [6:0]        seed_q, seed_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [3:0]        k_q, k_d;
  logic [3:0]        j_q, j_d;
  logic [5:0]        i_q, i_d;
  logic [6:0]        out_cnt_q, out_cnt_d;
  logic              skip_q, skip_d;
  logic              cap_q, cap_d;
  logic              ack_q, ack_d;
  logic              no_match_q, no_match_d;
  logic [3:0]        ptrn_idx_q, ptrn_idx_d;
  logic              mem_own_q, mem_own_d;
  logic [7:0]        mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic [6:0] ptrn_sel_c;
  logic [6:0] step_nxt;
  logic [6:0] plain_c;
  logic [6:0] seed_c;
  logic       perr_c;
  logic       keep_c;

  // Tap table is a shift register: after 9 loads entry k sits at bits [7k +: 7].
  always_comb begin
    ptrn_sel_c = '0;
    for (int n = 0; n < int'(PTRN_CNT); n++) begin
      if (k_q == 4'(n)) ptrn_sel_c = ptrn_q[n*7 +: 7];
    end
  end

  lfsr7_step u_step (
    .state_i (lfsr_q),
    .ptrn_i  (ptrn_sel_c),
    .next_o  (step_nxt)
  );

  assign plain_c = MemRdata[6:0] ^ lfsr_q;

`ifdef LFSR_DEC_PERR_EN
  assign perr_c = ^MemRdata;
`else
  logic unused_rdata_msb;
  assign perr_c           = 1'b0;
  assign unused_rdata_msb = MemRdata[7];
`endif

  assign keep_c = !skip_q || (plain_c != SPACE[6:0]) || perr_c;

  always_comb begin
    state_d     = state_q;
    ptrn_d      = ptrn_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    k_d         = k_q;
    j_d         = j_q;
    i_d         = i_q;
    out_cnt_d   = out_cnt_q;
    skip_d      = skip_q;
    cap_d       = mem_rd_en_q;
    ack_d       = ack_q;
    no_match_d  = no_match_q;
    ptrn_idx_d  = ptrn_idx_q;
    mem_own_d   = mem_own_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_wdata_d = mem_wdata_q;
    seed_c      = MemRdata[6:0] ^ SPACE[6:0];
    if (seed_c == '0) seed_c = 7'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d     = ST_LDPT;
          mem_own_d   = 1'b1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = PTRN_BASE;
          k_d         = '0;
        end
      end

      ST_LDPT: begin
        if (cap_q) begin
          ptrn_d      = {MemRdata[6:0], ptrn_q[PTRN_W-1:7]};
          mem_rd_en_d = 1'b1;
          if (k_q == 4'(PTRN_CNT-1)) begin
            state_d    = ST_SEED;
            k_d        = '0;
            mem_addr_d = CRYPT_BASE;
          end else begin
            k_d        = k_q + 4'd1;
            mem_addr_d = PTRN_BASE + 8'(k_q) + 8'd1;
          end
        end
      end

      ST_SEED: begin
        if (cap_q) begin
          state_d     = ST_SRCH;
          seed_d      = seed_c;
          lfsr_d      = seed_c;
          j_d         = 4'd1;
          k_d         = '0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = CRYPT_BASE + 8'd1;
        end
      end

      // Preamble byte j decrypts with the state one step past byte j-1.
      ST_SRCH: begin
        if (cap_q) begin
          if ((MemRdata[6:0] ^ step_nxt) == SPACE[6:0]) begin
            mem_rd_en_d = 1'b1;
            if (j_q == 4'(PRE_CHECK-1)) begin
              state_d    = ST_DEC;
              ptrn_idx_d = k_q;
              lfsr_d     = seed_q;
              i_d        = '0;
              out_cnt_d  = '0;
              skip_d     = 1'b1;
              mem_addr_d = CRYPT_BASE;
            end else begin
              lfsr_d     = step_nxt;
              j_d        = j_q + 4'd1;
              mem_addr_d = CRYPT_BASE + 8'(j_q) + 8'd1;
            end
          end else if (k_q == 4'(PTRN_CNT-1)) begin
            state_d    = ST_DONE;
            no_match_d = 1'b1;
            ack_d      = 1'b1;
            mem_own_d  = 1'b0;
            mem_addr_d = '0;
          end else begin
            k_d         = k_q + 4'd1;
            j_d         = 4'd1;
            lfsr_d      = seed_q;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = CRYPT_BASE + 8'd1;
          end
        end
      end

      // Capture -> optional write -> next issue; a skipped byte goes straight to the next issue.
      ST_DEC: begin
        if (cap_q) begin
          lfsr_d = step_nxt;
          i_d    = i_q + 6'd1;
          if (keep_c) begin
            skip_d      = 1'b0;
            mem_wr_en_d = 1'b1;
            mem_addr_d  = 8'(out_cnt_q[5:0]);
            mem_wdata_d = {perr_c, plain_c};
            out_cnt_d   = out_cnt_q + 7'd1;
          end
          if (i_q == 6'(OUT_LEN-1)) begin
            state_d = ST_PAD;
          end else if (!keep_c) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = CRYPT_BASE + 8'(i_q) + 8'd1;
          end
        end else if (mem_wr_en_q) begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = CRYPT_BASE + 8'(i_q);
        end
      end

      ST_PAD: begin
        if (out_cnt_q < 7'(OUT_LEN)) begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = 8'(out_cnt_q[5:0]);
          mem_wdata_d = SPACE;
          out_cnt_d   = out_cnt_q + 7'd1;
        end else begin
          state_d     = ST_DONE;
          ack_d       = 1'b1;
          mem_own_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end

      ST_DONE: begin
        if (!Start) begin
          state_d    = ST_IDLE;
          ack_d      = 1'b0;
          no_match_d = 1'b0;
          ptrn_idx_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      ptrn_q      <= '0;
      seed_q      <= '0;
      lfsr_q      <= '0;
      k_q         <= '0;
      j_q         <= '0;
      i_q         <= '0;
      out_cnt_q   <= '0;
      skip_q      <= 1'b0;
      cap_q       <= 1'b0;
      ack_q       <= 1'b0;
      no_match_q  <= 1'b0;
      ptrn_idx_q  <= '0;
      mem_own_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptrn_q      <= ptrn_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      k_q         <= k_d;
      j_q         <= j_d;
      i_q         <= i_d;
      out_cnt_q   <= out_cnt_d;
      skip_q      <= skip_d;
      cap_q       <= cap_d;
      ack_q       <= ack_d;
      no_match_q  <= no_match_d;
      ptrn_idx_q  <= ptrn_idx_d;
      mem_own_q   <= mem_own_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign Ack      = ack_q;
  assign NoMatch  = no_match_q;
  assign PtrnIdx  = ptrn_idx_q;
  assign MemOwn   = mem_own_q;
  assign MemAddr  = mem_addr_q;
  assign MemRdEn  = mem_rd_en_q;
  assign MemWrEn  = mem_wr_en_q;
  assign MemWdata = mem_wdata_q;

endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// Scoreboard bench for lfsr_decrypt_seq: data-memory model, expected-write queue, directed runs.
module tb_lfsr_decrypt_seq;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

`ifdef LFSR_DEC_PERR_EN
  localparam logic [7:0] FLIP_EXP = 8'hA4;
`else
  localparam logic [7:0] FLIP_EXP = 8'h24;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack, no_match, mem_own, mem_rd_en, mem_wr_en;
  logic [3:0] ptrn_idx;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;

  logic [7:0] dm      [256];
  logic [7:0] dm_init [256];
  logic       load = 1'b0;
  logic [7:0] plain   [64];
  logic [7:0] tbl     [9];
  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_vec = 0;
  int         n_err = 0;

  lfsr_decrypt_seq dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .Start    (start),
    .Ack      (ack),
    .NoMatch  (no_match),
    .PtrnIdx  (ptrn_idx),
    .MemOwn   (mem_own),
    .MemAddr  (mem_addr),
    .MemRdEn  (mem_rd_en),
    .MemWrEn  (mem_wr_en),
    .MemWdata (mem_wdata),
    .MemRdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, write commits at the edge, bulk preload when idle.
  always @(posedge clk) begin
    if (load) begin
      for (int n = 0; n < 256; n++) dm[n] <= dm_init[n];
    end else begin
      if (mem_wr_en) dm[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= dm[mem_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", 32'({mem_addr, mem_wdata}), 32'({mon_e.addr, mon_e.data}));
      end
    end
  end

  task automatic build_image(input logic [6:0] ptrn, input logic [6:0] init, input int flip_j);
    logic [6:0] s;
    logic [6:0] b;
    logic [7:0] enc;
    s = init;
    for (int n = 0; n < 256; n++) dm_init[n] = 8'h00;
    for (int n = 0; n < 64; n++) dm_init[n] = 8'hEE;
    for (int j = 0; j < 64; j++) begin
      b   = plain[j][6:0] ^ s;
      enc = {^b, b};
      if (j == flip_j) enc[2] = ~enc[2];
      dm_init[64+j] = enc;
      s = {s[5:0], ^(s & ptrn)};
    end
    for (int k = 0; k < 9; k++) dm_init[128+k] = tbl[k];
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Message text with its two leading spaces removed, then space fill to 64.
  task automatic push_expected(input bit flip);
    wr_t w;
    for (int a = 0; a < 64; a++) begin
      w.addr = 8'(a);
      w.data = (a < 34) ? plain[a+14] : 8'h20;
      if (flip && a == 16) w.data = FLIP_EXP;
      exp_q.push_back(w);
    end
  endtask

  task automatic run_to_ack();
    bit ok;
    ok = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 check("memown_rise", 32'(mem_own), 1);
    for (int c = 0; c < 1000; c++) begin
      if (ack) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("ack_within_budget", 32'(ok), 1);
    check("queue_drained", exp_q.size(), 0);
    check("memown_fall", 32'(mem_own), 0);
  endtask

  task automatic release_start();
    start = 1'b0;
    @(posedge clk);
    #1 check("ack_drop", 32'(ack), 0);
  endtask

  initial begin
    string msg;
    int    bad;
    msg = "  Two  spaces  in  between  ,  2  . ";
    for (int j = 0; j < 64; j++) begin
      if (j < 12 || j - 12 >= msg.len()) plain[j] = 8'h20;
      else plain[j] = msg[j-12];
    end
    tbl[0] = 8'h60; tbl[1] = 8'h48; tbl[2] = 8'h78;
    tbl[3] = 8'h72; tbl[4] = 8'h6A; tbl[5] = 8'h69;
    tbl[6] = 8'h5C; tbl[7] = 8'h7E; tbl[8] = 8'h7B;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 0);
    check("rst_nomatch", 32'(no_match), 0);
    check("rst_ptrnidx", 32'(ptrn_idx), 0);
    check("rst_memown", 32'(mem_own), 0);
    check("rst_rden", 32'(mem_rd_en), 0);
    check("rst_wren", 32'(mem_wr_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;

    // Run A: taps 0x60 at index 0, seed 71.
    build_image(7'h60, 7'd71, -1);
    push_expected(1'b0);
    run_to_ack();
    check("a_ptrnidx", 32'(ptrn_idx), 0);
    check("a_nomatch", 32'(no_match), 0);
    check("a_dm0", 32'(dm[0]), 32'h54);
    check("a_dm1", 32'(dm[1]), 32'h77);
    check("a_dm2", 32'(dm[2]), 32'h6F);
    bad = 0;
    for (int a = 34; a < 64; a++) if (dm[a] != 8'h20) bad++;
    check("a_tail_spaces", bad, 0);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1 if (!ack || mem_own || mem_rd_en) bad++;
    end
    check("start_held_no_relaunch", bad, 0);
    release_start();

    // Run B: taps 0x7B at index 8, seed 1.
    build_image(7'h7B, 7'd1, -1);
    push_expected(1'b0);
    run_to_ack();
    check("b_ptrnidx", 32'(ptrn_idx), 8);
    check("b_nomatch", 32'(no_match), 0);
    release_start();

    // Run C: bit 2 of encrypted byte 30 flipped.
    build_image(7'h60, 7'd71, 30);
    push_expected(1'b1);
    run_to_ack();
    check("c_dm16_flip", 32'(dm[16]), 32'(FLIP_EXP));
    check("c_dm15", 32'(dm[15]), 32'h20);
    release_start();

    // Run D: all-zero tap table never matches.
    for (int k = 0; k < 9; k++) tbl[k] = 8'h00;
    build_image(7'h60, 7'd71, -1);
    run_to_ack();
    check("d_nomatch", 32'(no_match), 1);
    bad = 0;
    for (int a = 0; a < 64; a++) if (dm[a] != 8'hEE) bad++;
    check("d_out_untouched", bad, 0);
    release_start();
    check("d_nomatch_clear", 32'(no_match), 0);

    // Run E: reset 100 cycles into a run, then a clean rerun.
    tbl[0] = 8'h60;
    build_image(7'h60, 7'd71, -1);
    push_expected(1'b0);
    start = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("e_rst_ack", 32'(ack), 0);
    check("e_rst_memown", 32'(mem_own), 0);
    check("e_rst_wren", 32'(mem_wr_en), 0);
    exp_q.delete();
    start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("e_idle_wren", 32'(mem_wr_en), 0);
    build_image(7'h60, 7'd71, -1);
    push_expected(1'b0);
    run_to_ack();
    check("e_ptrnidx", 32'(ptrn_idx), 0);
    check("e_dm0", 32'(dm[0]), 32'h54);
    release_start();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_decrypt_seq.md
# lfsr_decrypt_seq

Hardware sequencer for program 3: message decryption and leading-space removal. It drives the data-memory port to load the LFSR tap table and recover the LFSR pattern and seed from the known-space preamble. It then decrypts the 64 encrypted bytes at 64..127, strips the padding and leading message spaces, and writes the result to 0..63 with a parity-error flag in bit 7. It sits beside the core in TopLevel and shares the DM1 port; the core is stalled while the sequencer owns it.

## Interface
- PTRN_BASE, 128: DM address of the 9-entry tap-pattern table
- CRYPT_BASE, 64: DM address of the first encrypted byte
- PRE_CHECK, 10: number of preamble bytes that must decrypt to 0x20 for a pattern to match
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  request; rising level in IDLE launches a run
- Ack  out  1  run complete; held high until Start is low again
- NoMatch  out  1  no tap pattern matched; valid while Ack is high
- PtrnIdx  out  4  index (0..8) of the matched pattern; valid while Ack is high
- MemOwn  out  1  sequencer owns DM1 (core must not access it)
- MemAddr  out  8  DM address
- MemRdEn  out  1  read strobe; MemRdata is valid on the following cycle
- MemWrEn  out  1  write strobe; write commits at the edge
- MemWdata  out  8  write data
- MemRdata  in  8  read data

## Operation
- States:
  - IDLE: wait for Start.
  - LDPT: read 9 patterns into ptrn[0..8].
  - SEED: read CRYPT_BASE. The seed is byte[6:0]^0x20.
  - SRCH: for each k = 0..8, step the LFSR with ptrn[k] and compare bytes 1..PRE_CHECK-1 decrypted against 0x20.
    - First full match selects k.
    - Mismatch aborts k immediately and retries from the seed with k+1.
    - After k = 8 fails, set NoMatch and go to DONE.
  - DEC: for i = 0..63, read byte i. Plain = byte[6:0]^lfsr. perr = ^byte[7:0] (odd count of ones in the full byte means an error).
    - While skipping, bytes with plain == 0x20 and no perr are dropped.
    - The first other byte clears skipping.
    - Every subsequent byte is written to out_ptr++ as {perr, plain}.
  - PAD: write 0x20 to out_ptr..63.
  - DONE: assert Ack.
- LFSR step: next = {s[5:0], ^(s & ptrn)}. State 0 never occurs because the seed is forced to 1 if 0.
- Output addresses are 6-bit and stop at 63; out_ptr never wraps.
- Input index i is 6-bit; DEC ends after i = 63.
- In NoMatch runs, addresses 0..63 are not written.
- Reset mid-run: returns to IDLE on the next edge, with all outputs 0, MemOwn 0, and no further writes.

## Timing
- Reset values:
  - Ack 0, NoMatch 0, PtrnIdx 0
  - MemOwn 0, MemRdEn 0, MemWrEn 0, MemAddr 0, MemWdata 0
- MemOwn rises the cycle after Start is sampled high in IDLE and falls on entry to DONE.
- Each read takes 2 cycles: issue, then capture.
- Each DEC byte takes 2 cycles to read plus 1 write cycle if written. Each PAD byte takes 1 cycle.
- Worst-case run ≈ 18 + 2 + 9·2·9 + 64·3 + 64 cycles, which is under 450.
- Ack rises one cycle after the last write.
- Ack falls the cycle after Start is low, returning to IDLE.
- Start held high in DONE does not relaunch a run.
- Start toggling mid-run is ignored.

## Configuration
- LFSR_DEC_PERR_EN
  - Defined: bit 7 of every written byte is perr, and a byte with perr set is never dropped as a leading space.
  - Undefined: bit 7 is always written 0, perr logic is removed, and a skipped space is judged on plain only.

## Structure
- Package lfsr_dec_pkg holds:
  - state enum
  - SPACE = 8'h20
  - PTRN_CNT = 9
  - OUT_LEN = 64
  - address constants
- Sub-module lfsr7_step: combinational next-state from (state, ptrn), instantiated once.
- Top FSM and counters (k, j, i, out_ptr) live in lfsr_decrypt_seq.
- The DM1 port mux is in TopLevel, selected by MemOwn.

## Test plan
- Message "  Two  spaces  in  between  ,  2  . ", ptrn 0x60, init 71, pre 12, no flips:
  - Ack high, PtrnIdx 0, NoMatch 0.
  - DM[0] = 0x54 ('T'), DM[1] = 0x77, DM[2] = 0x6F.
  - Tail of 0..63 is 0x20.
- Same message with ptrn 0x7B (idx 8), init 1: PtrnIdx 8 and identical output.
- Flip bit 2 of encrypted byte 30:
  - Corresponding DM output has bit 7 = 1.
  - All other bytes match with bit 7 = 0.
  - Without LFSR_DEC_PERR_EN, that byte's bit 7 = 0.
- Pattern table all zeros: NoMatch 1, Ack high, DM[0..63] unchanged.
- Reset driven low at cycle 100 of a run:
  - Next cycle Ack 0, MemOwn 0, MemWrEn 0.
  - A following Start completes correctly.
- Start held high after Ack: no second run. Start low: Ack drops next cycle.
